// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared state encoding and width helper for the FIR MAC sequencer.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {LOAD, MAC, DRAIN, OUT} state_t;

    // Counter width that never collapses to zero bits for tiny parameters.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fir_vld_delay.sv
// fir_vld_delay: 1-bit valid delay line, DEPTH flops deep; DEPTH=0 is a plain wire.
module fir_vld_delay #(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    if (DEPTH == 0) begin : g_pass
        assign dout = din;
    end else begin : g_pipe
        logic [DEPTH-1:0] pipe;
        always_ff @(posedge clock or posedge reset)
            if (reset) pipe <= '0;
            else       pipe <= (pipe << 1) | DEPTH'(din);
        assign dout = pipe[DEPTH-1];
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control FSM that reads I/Q FIFOs, steps the complex MAC through
// TAPS coefficients, waits out the MAC pipeline and writes one result pair per output.
module fir_mac_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS       = 20,
    parameter int DECIMATION = 1,
    parameter int MAC_LAT    = 2,
    parameter int TAP_W      = clog2_min1(TAPS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_empty,
    input  logic             q_empty,
    output logic             i_rd_en,
    output logic             q_rd_en,
    output logic             shift_en,
    output logic             acc_clr,
    output logic [TAP_W-1:0] tap_addr,
    output logic             acc_en,
    input  logic             y_real_full,
    input  logic             y_imag_full,
    output logic             y_real_wr_en,
    output logic             y_imag_wr_en,
    output logic             busy,
    output logic [31:0]      out_count
);

    localparam int DW = clog2_min1(DECIMATION);
    localparam int LW = clog2_min1(MAC_LAT);
    localparam logic [DW-1:0]    DEC_LAST = DW'(DECIMATION - 1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
    localparam logic [LW-1:0]    LAT_LAST = LW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

    state_t state, state_nxt;
    logic [DW-1:0]    dec_cnt, dec_nxt;
    logic [TAP_W-1:0] tap_cnt, tap_nxt;
    logic [LW-1:0]    lat_cnt, lat_nxt;
    logic rd_en, wr_en, mac_vld;

    wire in_empty = i_empty | q_empty;
    wire out_full = y_real_full | y_imag_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= LOAD;
            dec_cnt   <= '0;
            tap_cnt   <= '0;
            lat_cnt   <= '0;
            tap_addr  <= '0;
            out_count <= '0;
        end else begin
            state   <= state_nxt;
            dec_cnt <= dec_nxt;
            tap_cnt <= tap_nxt;
            lat_cnt <= lat_nxt;
            // tap_addr tracks tap_cnt only while in MAC and holds otherwise
            if (state_nxt == MAC) tap_addr <= tap_nxt;
            if (wr_en) out_count <= out_count + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        dec_nxt   = dec_cnt;
        tap_nxt   = tap_cnt;
        lat_nxt   = lat_cnt;
        rd_en     = 1'b0;
        acc_clr   = 1'b0;
        wr_en     = 1'b0;
        mac_vld   = 1'b0;
        case (state)
            LOAD: if (!in_empty) begin
                rd_en   = 1'b1;
                dec_nxt = (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
                if (dec_cnt == DEC_LAST) begin
                    acc_clr   = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                mac_vld = 1'b1;
                tap_nxt = (tap_cnt == TAP_LAST) ? '0 : tap_cnt + 1'b1;
                if (tap_cnt == TAP_LAST) state_nxt = (MAC_LAT == 0) ? OUT : DRAIN;
            end
            DRAIN: begin
                lat_nxt = (lat_cnt == LAT_LAST) ? '0 : lat_cnt + 1'b1;
                if (lat_cnt == LAT_LAST) state_nxt = OUT;
            end
            OUT: if (!out_full) begin
                wr_en     = 1'b1;
                state_nxt = LOAD;
            end
            default: begin
                state_nxt = LOAD;
                dec_nxt   = '0;
                tap_nxt   = '0;
                lat_nxt   = '0;
            end
        endcase
    end

    assign i_rd_en      = rd_en;
    assign q_rd_en      = rd_en;
    assign shift_en     = rd_en;
    assign y_real_wr_en = wr_en;
    assign y_imag_wr_en = wr_en;
    assign busy         = (state != LOAD);

    fir_vld_delay #(.DEPTH(MAC_LAT)) u_vld (
        .clock (clock),
        .reset (reset),
        .din   (mac_vld),
        .dout  (acc_en)
    );

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: directed cycle-by-cycle checks of the FIR MAC sequencer
// in three configurations (20 taps/lat 2, decimate-by-4, single tap/lat 0).
module tb_fir_mac_sequencer;

    logic clock, reset;
    int n_cmp = 0;
    int n_bad = 0;

    logic a_i_empty, a_q_empty, a_i_rd, a_q_rd, a_shift, a_clr, a_acc;
    logic a_real_full, a_imag_full, a_wr_r, a_wr_i, a_busy;
    logic [4:0] a_tap;
    logic [31:0] a_cnt;

    logic b_i_empty, b_q_empty, b_i_rd, b_q_rd, b_shift, b_clr, b_acc;
    logic b_real_full, b_imag_full, b_wr_r, b_wr_i, b_busy;
    logic [4:0] b_tap;
    logic [31:0] b_cnt;

    logic c_i_empty, c_q_empty, c_i_rd, c_q_rd, c_shift, c_clr, c_acc;
    logic c_real_full, c_imag_full, c_wr_r, c_wr_i, c_busy;
    logic [0:0] c_tap;
    logic [31:0] c_cnt;

    fir_mac_sequencer #(.TAPS(20), .DECIMATION(1), .MAC_LAT(2)) dut_a (
        .clock(clock), .reset(reset), .i_empty(a_i_empty), .q_empty(a_q_empty),
        .i_rd_en(a_i_rd), .q_rd_en(a_q_rd), .shift_en(a_shift), .acc_clr(a_clr),
        .tap_addr(a_tap), .acc_en(a_acc), .y_real_full(a_real_full), .y_imag_full(a_imag_full),
        .y_real_wr_en(a_wr_r), .y_imag_wr_en(a_wr_i), .busy(a_busy), .out_count(a_cnt));

    fir_mac_sequencer #(.TAPS(20), .DECIMATION(4), .MAC_LAT(2)) dut_b (
        .clock(clock), .reset(reset), .i_empty(b_i_empty), .q_empty(b_q_empty),
        .i_rd_en(b_i_rd), .q_rd_en(b_q_rd), .shift_en(b_shift), .acc_clr(b_clr),
        .tap_addr(b_tap), .acc_en(b_acc), .y_real_full(b_real_full), .y_imag_full(b_imag_full),
        .y_real_wr_en(b_wr_r), .y_imag_wr_en(b_wr_i), .busy(b_busy), .out_count(b_cnt));

    fir_mac_sequencer #(.TAPS(1), .DECIMATION(1), .MAC_LAT(0)) dut_c (
        .clock(clock), .reset(reset), .i_empty(c_i_empty), .q_empty(c_q_empty),
        .i_rd_en(c_i_rd), .q_rd_en(c_q_rd), .shift_en(c_shift), .acc_clr(c_clr),
        .tap_addr(c_tap), .acc_en(c_acc), .y_real_full(c_real_full), .y_imag_full(c_imag_full),
        .y_real_wr_en(c_wr_r), .y_imag_wr_en(c_wr_i), .busy(c_busy), .out_count(c_cnt));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] pk(input logic [4:0] tap, input logic rd, qrd, sh, clr,
                                       input logic acc, wr, wri, bsy);
        return {19'b0, tap, rd, qrd, sh, clr, acc, wr, wri, bsy};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] obs_a();
        return pk(a_tap, a_i_rd, a_q_rd, a_shift, a_clr, a_acc, a_wr_r, a_wr_i, a_busy);
    endfunction

    // One sample into dut_a; imag-full held for fl cycles on entering OUT.
    task automatic run_a(input string t, input int fl, input bit queued, input logic [4:0] tap0);
        int last;
        last = 23 + fl;
        for (int c = 0; c <= last + 2; c++) begin
            @(negedge clock);
            a_i_empty   = !(c == 0 || (queued && c <= last));
            a_q_empty   = a_i_empty;
            a_imag_full = (c >= 23 && c < last);
            #1;
            check($sformatf("%s c%0d", t, c), obs_a(),
                  pk(c == 0 ? tap0 : (c <= 20 ? 5'(c - 1) : 5'd19),
                     c == 0, c == 0, c == 0, c == 0, c >= 3 && c <= 22,
                     c == last, c == last, c >= 1 && c <= last));
        end
        a_i_empty = 1'b1;
        a_q_empty = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        {a_i_empty, a_q_empty, b_i_empty, b_q_empty, c_i_empty, c_q_empty} = '1;
        {a_real_full, a_imag_full, b_real_full, b_imag_full, c_real_full, c_imag_full} = '0;
        repeat (2) @(negedge clock);
        #1;
        check("reset a", obs_a(), 32'd0);
        check("reset a cnt", a_cnt, 32'd0);
        check("reset b", pk(b_tap, b_i_rd, b_q_rd, b_shift, b_clr, b_acc, b_wr_r, b_wr_i, b_busy), 32'd0);
        check("reset c", pk({4'b0, c_tap}, c_i_rd, c_q_rd, c_shift, c_clr, c_acc, c_wr_r, c_wr_i, c_busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        run_a("T1", 0, 1'b0, 5'd0);
        check("T1 cnt", a_cnt, 32'd1);

        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            a_i_empty = (c >= 3);
            a_q_empty = (c < 3);
            #1;
            check($sformatf("T4 unpaired c%0d", c), obs_a(), pk(5'd19, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        run_a("T4", 0, 1'b0, 5'd19);
        check("T4 cnt", a_cnt, 32'd2);

        run_a("T3", 10, 1'b1, 5'd19);
        check("T3 cnt", a_cnt, 32'd3);

        for (int c = 0; c <= 8; c++) begin
            @(negedge clock);
            a_i_empty = (c != 0);
            a_q_empty = (c != 0);
            #1;
            check($sformatf("T5 c%0d", c), obs_a(),
                  pk(c == 0 ? 5'd19 : 5'(c - 1), c == 0, c == 0, c == 0, c == 0,
                     c >= 3, 0, 0, c >= 1));
        end
        reset = 1'b1;
        #1;
        check("T5 abort", obs_a(), 32'd0);
        check("T5 abort cnt", a_cnt, 32'd0);
        @(negedge clock);
        #1;
        check("T5 held", obs_a(), 32'd0);
        reset = 1'b0;
        run_a("T5 fresh", 0, 1'b0, 5'd0);
        check("T5 cnt", a_cnt, 32'd1);

        for (int c = 0; c <= 33; c++) begin
            logic rd;
            rd = (c == 0 || c == 3 || c == 5 || c == 8);
            @(negedge clock);
            b_i_empty = !rd;
            b_q_empty = !rd;
            #1;
            check($sformatf("T2 c%0d", c),
                  pk(b_tap, b_i_rd, b_q_rd, b_shift, b_clr, b_acc, b_wr_r, b_wr_i, b_busy),
                  pk(c <= 9 ? 5'd0 : (c <= 28 ? 5'(c - 9) : 5'd19), rd, rd, rd, c == 8,
                     c >= 11 && c <= 30, c == 31, c == 31, c >= 9 && c <= 31));
        end
        b_i_empty = 1'b1;
        b_q_empty = 1'b1;
        check("T2 cnt", b_cnt, 32'd1);

        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            c_i_empty = 1'b0;
            c_q_empty = 1'b0;
            #1;
            check($sformatf("T6 c%0d", c),
                  pk({4'b0, c_tap}, c_i_rd, c_q_rd, c_shift, c_clr, c_acc, c_wr_r, c_wr_i, c_busy),
                  pk(5'd0, c % 3 == 0, c % 3 == 0, c % 3 == 0, c % 3 == 0,
                     c % 3 == 1, c % 3 == 2, c % 3 == 2, c % 3 != 0));
            check($sformatf("T6 cnt c%0d", c), c_cnt, 32'(c / 3));
        end
        @(negedge clock);
        c_i_empty = 1'b1;
        c_q_empty = 1'b1;
        #1;
        check("T6 cnt end", c_cnt, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
